rv_unified_mem: RTL and testbench

Unified instruction/data memory for the RISC-V 5-stage pipeline core. It has two parts: a word-addressed instruction ROM/RAM read by the fetch stage (PC in Q100H, instruction out in Q101H), and a byte-addressed data RAM accessed by the memory stage (request in Q103H, load data out in Q104H). Both ports use synchronous, registered reads. The block sits beside `rv_cpu` and is driven directly by its fetch and memory-access signals.

---
 rtl/rv_unified_mem.sv | 121 ++++++++++++
 tb/tb_rv_unified_mem.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rv_unified_mem.sv
// rv_unified_mem: word-addressed instruction memory plus byte-lane data memory for the
// 5-stage core; both read ports are synchronous with registered outputs.

module rv_imem #(
   parameter int IMEM_SIZE_WORDS = 256,
   parameter int AW              = 8
) (
   input  logic [AW-1:0] i_addr,
   output logic [31:0]   o_rdata
);
   // Contents come only from hierarchical preload; the core never writes here.
   logic [31:0] mem [0:IMEM_SIZE_WORDS-1];

   assign o_rdata = mem[i_addr];
endmodule

module rv_unified_mem #(
   parameter int IMEM_SIZE_WORDS = 256,
   parameter int DMEM_SIZE_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_Q100H,
   input  logic        ready_Q101H,
   output logic [31:0] instruction_Q101H,
   input  logic [31:0] alu_out_Q103H,
   input  logic [31:0] dmem_wr_data_Q103H,
   input  logic        dmem_wr_en_Q103H,
   input  logic [3:0]  dmem_byte_en_Q103H,
   input  logic        dmem_is_signed_Q103H,
   output logic [31:0] dmem_rd_data_Q104H
);
   localparam int DWORDS = DMEM_SIZE_BYTES / 4;
   localparam int IAW    = (IMEM_SIZE_WORDS > 1) ? $clog2(IMEM_SIZE_WORDS) : 1;
   localparam int DAW    = (DWORDS > 1) ? $clog2(DWORDS) : 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

   logic [IAW-1:0] w_iidx;
   logic [31:0]    w_idata;
   logic [DAW-1:0] w_didx;
   logic [1:0]     w_off;
   size_e          w_size;
   logic [3:0]     w_wmask;
   logic [31:0]    w_wlane;
   logic           w_unused_pc_lsb;
   logic [31:0]    r_dmem [0:DWORDS-1];
   logic [31:0]    r_instr;
   logic [31:0]    r_rdata;

   assign w_iidx          = IAW'(pc_Q100H[31:2] % 30'(IMEM_SIZE_WORDS));
   assign w_unused_pc_lsb = ^pc_Q100H[1:0];
   assign w_didx          = DAW'(alu_out_Q103H[31:2] % 30'(DWORDS));
   assign w_off           = alu_out_Q103H[1:0];

   rv_imem #(.IMEM_SIZE_WORDS(IMEM_SIZE_WORDS), .AW(IAW)) i_mem (
      .i_addr  (w_iidx),
      .o_rdata (w_idata)
   );

   // Anything other than byte/half strobes is handled as a full word.
   always_comb begin
      case (dmem_byte_en_Q103H)
         4'b0001: w_size = SZ_BYTE;
         4'b0011: w_size = SZ_HALF;
         default: w_size = SZ_WORD;
      endcase
   end

   always_comb begin
      w_wmask = 4'b1111;
      w_wlane = dmem_wr_data_Q103H;
      case (w_size)
         SZ_BYTE: begin
            w_wmask = 4'b0001 << w_off;
            w_wlane = {4{dmem_wr_data_Q103H[7:0]}};
         end
         SZ_HALF: begin
            w_wmask = w_off[1] ? 4'b1100 : 4'b0011;
            w_wlane = {2{dmem_wr_data_Q103H[15:0]}};
         end
         default: ;
      endcase
   end

   function automatic logic [31:0] f_load_ext(input logic [31:0] word, input logic [1:0] off,
                                              input size_e size, input logic sgn);
      logic [31:0] sh_b;
      logic [31:0] sh_h;
      sh_b = word >> {off, 3'b000};
      sh_h = word >> {off[1], 4'b0000};
      case (size)
         SZ_BYTE: f_load_ext = {{24{sgn & sh_b[7]}}, sh_b[7:0]};
         SZ_HALF: f_load_ext = {{16{sgn & sh_h[15]}}, sh_h[15:0]};
         default: f_load_ext = word;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst && dmem_wr_en_Q103H) begin
         for (int b = 0; b < 4; b++) begin
            if (w_wmask[b]) r_dmem[w_didx][8*b +: 8] <= w_wlane[8*b +: 8];
         end
      end
   end

   // Q101H / Q104H output registers; the load path samples the array before this edge's store.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_instr <= NOP;
         r_rdata <= '0;
      end else begin
         if (ready_Q101H) r_instr <= w_idata;
         r_rdata <= f_load_ext(r_dmem[w_didx], w_off, w_size, dmem_is_signed_Q103H);
      end
   end

   assign instruction_Q101H  = r_instr;
   assign dmem_rd_data_Q104H = r_rdata;
endmodule

// File: tb/tb_rv_unified_mem.sv
// Bench for rv_unified_mem: directed fetch/load/store steps plus random traffic against a
// byte-array reference model.
`timescale 1ns/1ps
module tb_rv_unified_mem;
   localparam int IW = 256;
   localparam int DB = 1024;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        ready;
   logic [31:0] instr;
   logic [31:0] alu_out;
   logic [31:0] wr_data;
   logic        wr_en;
   logic [3:0]  byte_en;
   logic        is_signed;
   logic [31:0] rd_data;

   rv_unified_mem #(.IMEM_SIZE_WORDS(IW), .DMEM_SIZE_BYTES(DB)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .pc_Q100H             (pc),
      .ready_Q101H          (ready),
      .instruction_Q101H    (instr),
      .alu_out_Q103H        (alu_out),
      .dmem_wr_data_Q103H   (wr_data),
      .dmem_wr_en_Q103H     (wr_en),
      .dmem_byte_en_Q103H   (byte_en),
      .dmem_is_signed_Q103H (is_signed),
      .dmem_rd_data_Q104H   (rd_data)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] ref_imem [0:IW-1];
   logic [7:0]  ref_b [0:DB-1];
   logic [31:0] exp_instr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int sz_of(input logic [3:0] be);
      if (be == 4'b0001) return 1;
      if (be == 4'b0011) return 2;
      return 4;
   endfunction

   function automatic int base_of(input logic [31:0] a, input int sz);
      longint unsigned x = a;
      longint unsigned s = longint'(sz);
      return int'(((x - (x % s)) % longint'(DB)));
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [3:0] be, input logic sg);
      int sz = sz_of(be);
      int base = base_of(a, sz);
      longint unsigned v = 0;
      for (int i = 0; i < sz; i++) v = v | (longint'(ref_b[base + i]) << (8 * i));
      if (sg && sz < 4 && ((v >> (8 * sz - 1)) & 1) != 0) v = v | (64'hFFFF_FFFF << (8 * sz));
      return v[31:0];
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
      int sz = sz_of(be);
      int base = base_of(a, sz);
      for (int i = 0; i < sz; i++) ref_b[base + i] = wd[8*i +: 8];
   endtask

   task automatic fstep(input logic [31:0] p, input logic rdy, input string tag);
      pc = p;
      ready = rdy;
      if (!rst) exp_instr = NOP;
      else if (rdy) exp_instr = ref_imem[int'((p >> 2) % 32'(IW))];
      step();
      chk(tag, instr, exp_instr);
   endtask

   task automatic dacc(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic [3:0] be, input logic sg, input string tag);
      logic [31:0] exp;
      alu_out = a;
      wr_data = wd;
      wr_en = we;
      byte_en = be;
      is_signed = sg;
      exp = rst ? ref_load(a, be, sg) : 32'h0;
      step();
      if (rst && we) ref_store(a, wd, be);
      chk(tag, rd_data, exp);
      wr_en = 1'b0;
   endtask

   initial begin
      logic [3:0] be_tab [4];
      be_tab[0] = 4'b0001; be_tab[1] = 4'b0011; be_tab[2] = 4'b1111; be_tab[3] = 4'b0110;
      for (int k = 0; k < IW; k++) ref_imem[k] = $urandom;
      ref_imem[0] = 32'h0050_0093;
      ref_imem[1] = 32'h00A0_0113;
      ref_imem[2] = 32'h0020_81B3;
      ref_imem[3] = 32'h0000_0013;
      for (int k = 0; k < IW; k++) dut.i_mem.mem[k] = ref_imem[k];

      rst = 1'b0; pc = 32'h4; ready = 1'b1;
      alu_out = 32'h10; wr_data = 32'h0; wr_en = 1'b1; byte_en = 4'b1111; is_signed = 1'b0;
      step();
      chk("reset_instr", instr, NOP);
      chk("reset_rdata", rd_data, 32'h0);
      step();
      chk("reset_instr_ready", instr, NOP);

      // Fill data memory through the store port so the model starts fully known.
      rst = 1'b1; ready = 1'b0; exp_instr = NOP;
      for (int w = 0; w < DB / 4; w++) begin
         alu_out = 32'(4 * w); wr_data = $urandom; wr_en = 1'b1; byte_en = 4'b1111;
         step();
         ref_store(alu_out, wr_data, byte_en);
      end
      wr_en = 1'b0;
      chk("hold_after_reset", instr, NOP);

      fstep(32'h0, 1'b1, "fetch0");  chk("fetch0_lit", instr, 32'h0050_0093);
      fstep(32'h4, 1'b1, "fetch1");  chk("fetch1_lit", instr, 32'h00A0_0113);
      fstep(32'h8, 1'b1, "fetch2");  chk("fetch2_lit", instr, 32'h0020_81B3);
      fstep(32'hC, 1'b1, "fetch3");  chk("fetch3_lit", instr, 32'h0000_0013);
      fstep(32'h8, 1'b0, "stall0");
      fstep(32'h14, 1'b0, "stall1");
      fstep(32'h400, 1'b1, "wrap_pc"); chk("wrap_pc_lit", instr, 32'h0050_0093);
      fstep(32'h406, 1'b1, "pc_lsb_ign"); chk("pc_lsb_lit", instr, 32'h00A0_0113);
      for (int i = 0; i < 40; i++) fstep($urandom, ($urandom_range(0, 3) != 0), "rand_fetch");
      rst = 1'b0; fstep(32'h8, 1'b1, "reset_prio");
      rst = 1'b1; fstep(32'h8, 1'b1, "post_reset_fetch"); chk("post_reset_lit", instr, 32'h0020_81B3);

      ready = 1'b0;
      dacc(32'h10, 32'hDEAD_BEEF, 1'b1, 4'b1111, 1'b0, "st_w");
      dacc(32'h10, 32'h0, 1'b0, 4'b1111, 1'b0, "ld_w");   chk("ld_w_lit", rd_data, 32'hDEAD_BEEF);
      dacc(32'h13, 32'h0, 1'b0, 4'b0001, 1'b1, "ld_sb");  chk("ld_sb_lit", rd_data, 32'hFFFF_FFDE);
      dacc(32'h13, 32'h0, 1'b0, 4'b0001, 1'b0, "ld_ub");  chk("ld_ub_lit", rd_data, 32'h0000_00DE);
      dacc(32'h11, 32'hAAAA_AA7F, 1'b1, 4'b0001, 1'b0, "st_b");
      dacc(32'h10, 32'h0, 1'b0, 4'b1111, 1'b0, "ld_w2");  chk("ld_w2_lit", rd_data, 32'hDEAD_7FEF);
      dacc(32'h12, 32'h0, 1'b0, 4'b0011, 1'b1, "ld_sh");  chk("ld_sh_lit", rd_data, 32'hFFFF_DEAD);
      dacc(32'h10, 32'h0, 1'b0, 4'b0011, 1'b0, "ld_uh");  chk("ld_uh_lit", rd_data, 32'h0000_7FEF);
      dacc(32'h20, 32'hCAFE_F00D, 1'b1, 4'b1111, 1'b0, "st_rdw0");
      dacc(32'h20, 32'h1234_5678, 1'b1, 4'b1111, 1'b0, "rdw_old"); chk("rdw_old_lit", rd_data, 32'hCAFE_F00D);
      dacc(32'h20, 32'h0, 1'b0, 4'b1111, 1'b0, "rdw_new"); chk("rdw_new_lit", rd_data, 32'h1234_5678);
      dacc(32'h23, 32'hFFFF_BEEF, 1'b1, 4'b0011, 1'b0, "st_h_odd");
      dacc(32'h20, 32'h0, 1'b0, 4'b1111, 1'b0, "ld_after_h"); chk("st_h_lit", rd_data, 32'hBEEF_5678);
      dacc(32'(DB + 5), 32'h0000_00A5, 1'b1, 4'b0001, 1'b0, "st_wrap");
      dacc(32'h5, 32'h0, 1'b0, 4'b0001, 1'b0, "ld_wrap"); chk("ld_wrap_lit", rd_data, 32'h0000_00A5);
      dacc(32'h31, 32'h0102_0304, 1'b1, 4'b0101, 1'b0, "st_odd_be");
      dacc(32'h30, 32'h0, 1'b0, 4'b1111, 1'b0, "ld_odd_be"); chk("odd_be_lit", rd_data, 32'h0102_0304);

      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 2 * DB - 1));
         dacc(a, $urandom, 1'($urandom_range(0, 1)), be_tab[$urandom_range(0, 3)],
              1'($urandom_range(0, 1)), "rand_data");
      end

      rst = 1'b0;
      dacc(32'h10, 32'hFFFF_FFFF, 1'b1, 4'b1111, 1'b0, "reset_store_rd");
      chk("reset_store_instr", instr, NOP);
      rst = 1'b1;
      dacc(32'h10, 32'h0, 1'b0, 4'b1111, 1'b0, "reset_store_ignored");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
